// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder: one full-adder cell with a registered carry, LSB first.
// Operands load on start; sum/cout/ovf are published with a single-cycle done pulse.
module serial_adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH-1:0] res_shifted;

  assign bit_sum     = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_carry   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign res_shifted = {bit_sum, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start exactly like IDLE, so back-to-back runs lose no cycle.
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_shifted;
        carry_d = bit_carry;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB, bit_carry the carry out of it.
          state_d = DONE;
          sum_d   = res_shifted;
          cout_d  = bit_carry;
          ovf_d   = carry_q ^ bit_carry;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit: 8-bit vector table and handshake sequences, plus a
// 4-bit exhaustive sweep; expected results flow through per-instance scoreboards.
module tb_serial_adder_nbit;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       s8_start, s8_cin, s8_busy, s8_done, s8_cout, s8_ovf;
  logic [7:0] s8_a, s8_b, s8_sum;
  logic       s4_start, s4_cin, s4_busy, s4_done, s4_cout, s4_ovf;
  logic [3:0] s4_a, s4_b, s4_sum;

  int   n_checks;
  int   n_errors;
  exp_t q8[$];
  exp_t q4[$];
  logic [7:0] held8;
  logic [3:0] held4;

  serial_adder_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b), .cin(s8_cin),
    .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf)
  );

  serial_adder_nbit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4_start), .a(s4_a), .b(s4_b), .cin(s4_cin),
    .busy(s4_busy), .done(s4_done), .sum(s4_sum), .cout(s4_cout), .ovf(s4_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every done pops one expected result; sum must hold while busy.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (s8_busy) begin
        n_checks++;
        if (s8_sum !== held8) begin
          n_errors++;
          $display("FAIL sum_stable8: sum=%h while busy, held value %h", s8_sum, held8);
        end
      end
      if (s8_done) begin
        n_checks++;
        if (q8.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_done8: done pulsed with no pending addition (sum=%h)", s8_sum);
        end else begin
          e = q8.pop_front();
          if ({s8_sum, s8_cout, s8_ovf} !== {e.sum, e.cout, e.ovf}) begin
            n_errors++;
            $display("FAIL result8: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     s8_sum, s8_cout, s8_ovf, e.sum, e.cout, e.ovf);
          end else begin
            $display("add8 sum=%h cout=%b ovf=%b ok", s8_sum, s8_cout, s8_ovf);
          end
          held8 = e.sum;
        end
      end
      if (s4_busy) begin
        n_checks++;
        if (s4_sum !== held4) begin
          n_errors++;
          $display("FAIL sum_stable4: sum=%h while busy, held value %h", s4_sum, held4);
        end
      end
      if (s4_done) begin
        n_checks++;
        if (q4.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_done4: done pulsed with no pending addition (sum=%h)", s4_sum);
        end else begin
          e = q4.pop_front();
          if ({s4_sum, s4_cout, s4_ovf} !== {e.sum[3:0], e.cout, e.ovf}) begin
            n_errors++;
            $display("FAIL result4: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     s4_sum, s4_cout, s4_ovf, e.sum[3:0], e.cout, e.ovf);
          end else begin
            $display("add4 sum=%h cout=%b ovf=%b ok", s4_sum, s4_cout, s4_ovf);
          end
          held4 = e.sum[3:0];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Called at a negedge; returns on the negedge where done is high (or on timeout).
  task automatic wait_done(input bit sel4, output int steps, output int busy_n);
    steps  = 0;
    busy_n = 0;
    while (!(sel4 ? s4_done : s8_done) && steps < 40) begin
      if (sel4 ? s4_busy : s8_busy) busy_n++;
      @(negedge clk);
      steps++;
    end
    n_checks++;
    if (!(sel4 ? s4_done : s8_done)) begin
      n_errors++;
      $display("FAIL done_timeout: no done within %0d cycles (dut%0d)", steps, sel4 ? 4 : 8);
    end
  endtask

  task automatic run8(input vec_t v);
    int steps, busy_n;
    exp_t e;
    e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf;
    q8.push_back(e);
    s8_a = v.a; s8_b = v.b; s8_cin = v.cin; s8_start = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
    s8_a = $urandom; s8_b = $urandom; s8_cin = $urandom;
    wait_done(1'b0, steps, busy_n);
    check("latency8", steps, 8);
    check("busy_cycles8", busy_n, 8);
    @(negedge clk);
  endtask

  task automatic run4(input int a, input int b, input int c);
    int steps, busy_n, sa, sb, sv, total;
    exp_t e;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    sv = sa + sb + c;
    total = a + b + c;
    e.sum  = 8'(total & 15);
    e.cout = (total >= 16);
    e.ovf  = (sv > 7) || (sv < -8);
    q4.push_back(e);
    s4_a = 4'(a); s4_b = 4'(b); s4_cin = c[0]; s4_start = 1'b1;
    @(negedge clk);
    s4_start = 1'b0;
    wait_done(1'b1, steps, busy_n);
    check("latency4", steps, 4);
    @(negedge clk);
  endtask

  vec_t tbl[9];

  initial begin
    int   steps, busy_n;
    bit   saw_done;
    exp_t e;

    tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    tbl[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[8] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};

    n_checks = 0; n_errors = 0;
    held8 = '0; held4 = '0;
    rst = 1'b1;
    s8_start = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0;
    s4_start = 1'b0; s4_a = '0; s4_b = '0; s4_cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy8", s8_busy, 0);
    check("reset_done8", s8_done, 0);
    check("reset_out8", {s8_sum, s8_cout, s8_ovf}, 0);
    check("reset_out4", {s4_busy, s4_done, s4_sum, s4_cout, s4_ovf}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run8(tbl[i]);

    // Reset in the middle of a run: everything clears and no done follows.
    e.sum = 8'h00; e.cout = 1'b1; e.ovf = 1'b0;
    q8.push_back(e);
    s8_a = 8'hFF; s8_b = 8'h01; s8_cin = 1'b0; s8_start = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", s8_busy, 0);
    check("midrst_done", s8_done, 0);
    check("midrst_out", {s8_sum, s8_cout, s8_ovf}, 0);
    q8.delete();
    held8 = '0;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s8_done) saw_done = 1'b1;
    end
    check("no_done_after_rst", saw_done, 0);
    run8('{8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0});

    // start pulses at RUN cycles 2 and 5 must be ignored.
    e.sum = 8'h33; e.cout = 1'b0; e.ovf = 1'b0;
    q8.push_back(e);
    s8_a = 8'h11; s8_b = 8'h22; s8_cin = 1'b0; s8_start = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 7; i++) begin
      s8_start = (i == 2 || i == 5);
      s8_a = $urandom; s8_b = $urandom; s8_cin = $urandom;
      @(negedge clk);
    end
    s8_start = 1'b0;
    wait_done(1'b0, steps, busy_n);
    check("ignored_start_latency", steps, 1);
    repeat (12) @(negedge clk);
    check("ignored_start_no_extra", q8.size(), 0);

    // start held high: a result every WIDTH+1 cycles.
    s8_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s8_a = 8'(8'h1F * k + 8'h0A);
      s8_b = 8'(8'h33 * k + 8'h70);
      s8_cin = k[0];
      e.sum  = 8'(s8_a + s8_b + {7'd0, s8_cin});
      e.cout = ({1'b0, s8_a} + {1'b0, s8_b} + {8'd0, s8_cin}) > 9'd255;
      e.ovf  = ($signed({s8_a[7], s8_a}) + $signed({s8_b[7], s8_b}) + $signed({8'd0, s8_cin}) > 9'sd127) ||
               ($signed({s8_a[7], s8_a}) + $signed({s8_b[7], s8_b}) + $signed({8'd0, s8_cin}) < -9'sd128);
      q8.push_back(e);
      if (k == 0) begin
        @(negedge clk);
      end else begin
        wait_done(1'b0, steps, busy_n);
        check("held_start_period", steps, 8);
        @(negedge clk);
      end
      if (k == 0) begin
        s8_a = $urandom; s8_b = $urandom;
      end
    end
    s8_start = 1'b0;
    wait_done(1'b0, steps, busy_n);
    check("held_start_period_last", steps, 8);
    @(negedge clk);
    check("held_start_drained", q8.size(), 0);

    // Exhaustive WIDTH=4 sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run4(a, b, c);
    check("sweep_drained", q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
